// File: rtl/frame_buffer_writer.sv
// Write-side controller for the ping-pong frame buffers: packs host R,G,B bytes
// into 24-bit pixels and writes whole frames alternately into Buf0 and Buf1.
module frame_buffer_writer #(
    parameter int ROWS   = 100,
    parameter int COLS   = 16,
    parameter int ADDR_W = 11
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              CSHost,
    input  logic [7:0]        DataIn,
    input  logic              DataValid,
    output logic              DataReady,
    input  logic              Buf0Empty,
    input  logic              Buf1Empty,
    output logic              WE0,
    output logic              WE1,
    output logic [23:0]       WrData,
    output logic [ADDR_W-1:0] Addr0,
    output logic [ADDR_W-1:0] Addr1,
    output logic [6:0]        row0,
    output logic [6:0]        row1,
    output logic              Buf0Full,
    output logic              Buf1Full,
    output logic              FrameDone,
    output logic [1:0]        dbg_state
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROWS * COLS - 1);
    localparam logic [6:0]        LAST_ROW  = 7'(ROWS - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);

    typedef enum logic [1:0] {SEL = 2'd0, FILL0 = 2'd1, FILL1 = 2'd2, DONE = 2'd3} state_t;

    state_t           state, state_nx;
    logic             target;
    logic [1:0]       phase;
    logic [7:0]       r_byte, g_byte;
    logic [COL_W-1:0] col;
    logic             sel_go;
    logic             accept, pix_done, frame_end;
    logic [6:0]       wr_row;
    logic             adv0, adv1;

    // Handshake: a byte transfers on a rising edge where DataValid, DataReady
    // and CSHost are all high; DataReady never depends on DataValid.
    assign DataReady = CSHost && (state == FILL0 || state == FILL1);
    assign accept    = DataValid && DataReady;
    assign pix_done  = accept && (phase == 2'd2);
    assign wr_row    = target ? row1 : row0;
    assign frame_end = pix_done && (wr_row == LAST_ROW) && (col == LAST_COL);
    assign dbg_state = state;

    // Address/row advance on the edge closing a write, except after the last pixel.
    assign adv0 = WE0 && (Addr0 != LAST_ADDR);
    assign adv1 = WE1 && (Addr1 != LAST_ADDR);

    always_comb begin
        state_nx = state;
        sel_go   = 1'b0;
        case (state)
            SEL: begin
                if (CSHost && !(target ? Buf1Full : Buf0Full)) begin
                    sel_go   = 1'b1;
                    state_nx = target ? FILL1 : FILL0;
                end
            end
            FILL0, FILL1: begin
                if (frame_end) state_nx = DONE;
            end
            DONE: begin
                if (CSHost) state_nx = SEL;
            end
            default: state_nx = SEL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= SEL;
            target <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == DONE && CSHost) target <= ~target;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase     <= 2'd0;
            r_byte    <= 8'd0;
            g_byte    <= 8'd0;
            WE0       <= 1'b0;
            WE1       <= 1'b0;
            WrData    <= 24'd0;
            FrameDone <= 1'b0;
        end else begin
            WE0       <= pix_done && !target;
            WE1       <= pix_done && target;
            FrameDone <= frame_end;
            if (accept) begin
                phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
                if (phase == 2'd0) r_byte <= DataIn;
                if (phase == 2'd1) g_byte <= DataIn;
                if (phase == 2'd2) WrData <= {r_byte, g_byte, DataIn};
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            Addr0 <= '0;
            Addr1 <= '0;
            row0  <= 7'd0;
            row1  <= 7'd0;
            col   <= '0;
        end else begin
            if (sel_go) col <= '0;
            else if (adv0 || adv1) col <= (col == LAST_COL) ? '0 : col + COL_W'(1);

            if (sel_go && !target) begin
                Addr0 <= '0;
                row0  <= 7'd0;
            end else if (adv0) begin
                Addr0 <= Addr0 + ADDR_W'(1);
                if (col == LAST_COL) row0 <= row0 + 7'd1;
            end

            if (sel_go && target) begin
                Addr1 <= '0;
                row1  <= 7'd0;
            end else if (adv1) begin
                Addr1 <= Addr1 + ADDR_W'(1);
                if (col == LAST_COL) row1 <= row1 + 7'd1;
            end
        end
    end

    // A completing frame sets its flag even if the reader releases on the same edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            Buf0Full <= 1'b0;
            Buf1Full <= 1'b0;
        end else begin
            if (frame_end && !target) Buf0Full <= 1'b1;
            else if (Buf0Empty)       Buf0Full <= 1'b0;
            if (frame_end && target)  Buf1Full <= 1'b1;
            else if (Buf1Empty)       Buf1Full <= 1'b0;
        end
    end

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Bench for frame_buffer_writer (2x2 frames): directed scenarios plus a random
// stream checked against a frame/pixel-count reference model.
module tb_frame_buffer_writer;

    localparam int ROWS   = 2;
    localparam int COLS   = 2;
    localparam int ADDR_W = 11;
    localparam int NPIX   = ROWS * COLS;
    localparam int W      = 44;

    logic              clock;
    logic              reset;
    logic              CSHost;
    logic [7:0]        DataIn;
    logic              DataValid;
    logic              DataReady;
    logic              Buf0Empty;
    logic              Buf1Empty;
    logic              WE0;
    logic              WE1;
    logic [23:0]       WrData;
    logic [ADDR_W-1:0] Addr0;
    logic [ADDR_W-1:0] Addr1;
    logic [6:0]        row0;
    logic [6:0]        row1;
    logic              Buf0Full;
    logic              Buf1Full;
    logic              FrameDone;
    logic [1:0]        dbg_state;

    frame_buffer_writer #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset), .CSHost(CSHost), .DataIn(DataIn),
        .DataValid(DataValid), .DataReady(DataReady), .Buf0Empty(Buf0Empty),
        .Buf1Empty(Buf1Empty), .WE0(WE0), .WE1(WE1), .WrData(WrData),
        .Addr0(Addr0), .Addr1(Addr1), .row0(row0), .row1(row1),
        .Buf0Full(Buf0Full), .Buf1Full(Buf1Full), .FrameDone(FrameDone),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // scoreboard: {buf, last, row[6:0], addr[10:0], data[23:0]}
    logic [W-1:0] exp_q[$];
    logic [W-1:0] e;
    int           m_nbytes, m_pix, m_frame, m_buf;
    logic [7:0]   m_r, m_g;
    logic         m_full0, m_full1, set0, set1;

    always @(negedge clock) begin
        if (!reset) begin
            exp_q.delete();
            m_nbytes = 0; m_pix = 0; m_frame = 0;
            m_full0 = 1'b0; m_full1 = 1'b0;
        end else begin
            check("full0", Buf0Full, m_full0);
            check("full1", Buf1Full, m_full1);
            check("we_excl", WE0 && WE1, 0);
            if (!CSHost) check("ready_cs", DataReady, 0);
            if (WE0 || WE1) begin
                if (exp_q.size() == 0) begin
                    check("we_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_buf", WE1, e[43]);
                    check("sb_addr", WE1 ? Addr1 : Addr0, e[34:24]);
                    check("sb_row", WE1 ? row1 : row0, e[41:35]);
                    check("sb_data", WrData, e[23:0]);
                    check("sb_fdone", FrameDone, e[42]);
                end
            end else begin
                check("fdone_idle", FrameDone, 0);
            end
            // predict the coming edge
            set0 = 1'b0; set1 = 1'b0;
            if (DataValid && DataReady && CSHost) begin
                if (m_nbytes == 0) m_r = DataIn;
                else if (m_nbytes == 1) m_g = DataIn;
                else begin
                    m_buf = m_frame % 2;
                    exp_q.push_back({m_buf[0], m_pix == NPIX - 1, 7'(m_pix / COLS),
                                     ADDR_W'(m_pix), m_r, m_g, DataIn});
                    m_pix++;
                    if (m_pix == NPIX) begin
                        m_pix = 0;
                        m_frame++;
                        if (m_buf == 0) set0 = 1'b1; else set1 = 1'b1;
                    end
                end
                m_nbytes = (m_nbytes + 1) % 3;
            end
            m_full0 = set0 ? 1'b1 : (Buf0Empty ? 1'b0 : m_full0);
            m_full1 = set1 ? 1'b1 : (Buf1Empty ? 1'b0 : m_full1);
        end
    end

    // driver tasks
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        @(posedge clock); #1;
        DataIn = b;
        DataValid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (DataReady) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ready_timeout", 0, 1);
        @(posedge clock); #1;
        DataValid = 1'b0;
    endtask

    task automatic send_pixel(input logic [23:0] p);
        send_byte(p[23:16]);
        send_byte(p[15:8]);
        send_byte(p[7:0]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, DataReady, 0);
        check({tag, "_we0"}, WE0, 0);
        check({tag, "_we1"}, WE1, 0);
        check({tag, "_wrdata"}, WrData, 0);
        check({tag, "_addr0"}, Addr0, 0);
        check({tag, "_addr1"}, Addr1, 0);
        check({tag, "_row0"}, row0, 0);
        check({tag, "_row1"}, row1, 0);
        check({tag, "_full0"}, Buf0Full, 0);
        check({tag, "_full1"}, Buf1Full, 0);
        check({tag, "_fdone"}, FrameDone, 0);
    endtask

    initial begin
        reset = 1'b0; CSHost = 1'b0; DataValid = 1'b0; DataIn = 8'd0;
        Buf0Empty = 1'b0; Buf1Empty = 1'b0;
        #2;
        check_all_zero("rst");
        check("rst_state", dbg_state, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        CSHost = 1'b1;

        // first pixel into Buf0
        send_pixel(24'h112233);
        @(negedge clock);
        check("p0_we0", WE0, 1);
        check("p0_we1", WE1, 0);
        check("p0_data", WrData, 24'h112233);
        check("p0_addr0", Addr0, 0);
        check("p0_row0", row0, 0);
        @(negedge clock);
        check("p0_addr0_inc", Addr0, 1);
        check("p0_we0_off", WE0, 0);

        // rest of frame 0
        send_pixel(24'h445566);
        @(negedge clock);
        check("p1_row0", row0, 0);
        send_pixel(24'h778899);
        @(negedge clock);
        check("p2_row0", row0, 1);
        check("p2_addr0", Addr0, 2);
        send_pixel(24'hAABBCC);
        @(negedge clock);
        check("p3_we0", WE0, 1);
        check("p3_fdone", FrameDone, 1);
        check("p3_full0", Buf0Full, 1);
        check("p3_row0", row0, 1);
        check("p3_addr0", Addr0, 3);
        check("done_ready", DataReady, 0);
        @(negedge clock);
        check("sel_ready", DataReady, 0);
        @(negedge clock);
        check("fill1_ready", DataReady, 1);
        check("fill1_addr1", Addr1, 0);
        check("fill1_row1", row1, 0);
        check("hold_addr0", Addr0, 3);
        check("hold_row0", row0, 1);
        send_pixel(24'h010203);
        @(negedge clock);
        check("b1_we1", WE1, 1);
        check("b1_we0", WE0, 0);
        check("b1_addr1", Addr1, 0);
        check("b1_data", WrData, 24'h010203);

        // finish Buf1, writer must park
        for (int i = 0; i < 3; i++) send_pixel(24'($urandom));
        @(negedge clock);
        check("b1_full", Buf1Full, 1);
        check("b1_fdone", FrameDone, 1);
        repeat (4) @(negedge clock);
        check("park_ready", DataReady, 0);
        check("park_full0", Buf0Full, 1);
        check("park_addr0", Addr0, 3);
        @(posedge clock); #1;
        Buf0Empty = 1'b1;
        @(posedge clock); #1;
        Buf0Empty = 1'b0;
        @(negedge clock);
        check("rel_full0", Buf0Full, 0);
        check("rel_ready_early", DataReady, 0);
        @(negedge clock);
        check("rel_ready", DataReady, 1);
        check("rel_addr0", Addr0, 0);
        check("rel_row0", row0, 0);
        check("rel_full1", Buf1Full, 1);

        // CSHost gap between R and G
        send_byte(8'hA1);
        @(posedge clock); #1;
        CSHost = 1'b0; DataValid = 1'b1; DataIn = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("gap_ready", DataReady, 0);
        end
        @(posedge clock); #1;
        CSHost = 1'b1; DataValid = 1'b0;
        send_byte(8'hB2);
        send_byte(8'hC3);
        @(negedge clock);
        check("gap_we0", WE0, 1);
        check("gap_data", WrData, 24'hA1B2C3);
        check("gap_addr0", Addr0, 0);

        // asynchronous reset in the middle of pixel 2
        send_pixel(24'h102030);
        send_byte(8'h40);
        @(posedge clock); #3;
        reset = 1'b0;
        #1;
        check_all_zero("mid_rst");
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        send_pixel(24'hDDEEFF);
        @(negedge clock);
        check("post_rst_we0", WE0, 1);
        check("post_rst_addr0", Addr0, 0);
        check("post_rst_data", WrData, 24'hDDEEFF);

        // Buf1 completes on the same edge Buf1Empty is high
        for (int i = 0; i < 3; i++) send_pixel(24'($urandom));
        for (int i = 0; i < 3; i++) send_pixel(24'($urandom));
        send_byte(8'h5A);
        send_byte(8'h6B);
        Buf1Empty = 1'b1;
        send_byte(8'h7C);
        Buf1Empty = 1'b0;
        @(negedge clock);
        check("coinc_we1", WE1, 1);
        check("coinc_full1", Buf1Full, 1);
        check("coinc_fdone", FrameDone, 1);
        check("coinc_data", WrData, 24'h5A6B7C);
        @(negedge clock);
        check("coinc_full1_hold", Buf1Full, 1);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            @(posedge clock); #1;
            CSHost    = ($urandom_range(0, 7) != 0);
            DataValid = ($urandom_range(0, 3) != 0);
            DataIn    = 8'($urandom);
            Buf0Empty = ($urandom_range(0, 5) == 0);
            Buf1Empty = ($urandom_range(0, 5) == 0);
        end
        @(posedge clock); #1;
        DataValid = 1'b0; CSHost = 1'b1; Buf0Empty = 1'b0; Buf1Empty = 1'b0;
        repeat (5) @(negedge clock);
        check("drain", exp_q.size(), 0);
        check("progress", m_frame > 10, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/frame_buffer_writer.md
Name: frame_buffer_writer

Overview:
- Write-side controller for the ping-pong frame buffers (Buf0/Buf1) that the display controller reads.
- Accepts a host byte stream in R, G, B order with a valid/ready handshake and packs each three bytes into one 24-bit pixel word.
- Writes each pixel word into whichever buffer the display side has released. It drives WE0/WE1, linear addresses and the row0/row1 progress counters.
- Alternates buffers every frame and never overwrites a buffer the reader still holds.

Parameters:
- ROWS, 100, rows per frame (max 128; row outputs are 7 bits, last row index is 7'b1100011 at default).
- COLS, 16, pixels per row.
- ADDR_W, 11, buffer address width (must cover ROWS*COLS words).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- CSHost  in  1  block enable; when low, no byte is accepted and all state holds.
- DataIn  in  8  host byte (R, G, B sequence).
- DataValid  in  1  host byte valid.
- DataReady  out  1  writer can accept a byte.
- Buf0Empty  in  1  reader has released Buf0 (level, sampled each edge).
- Buf1Empty  in  1  reader has released Buf1.
- WE0  out  1  one-cycle write strobe to Buf0.
- WE1  out  1  one-cycle write strobe to Buf1.
- WrData  out  24  packed pixel {R,G,B}, valid while WE0/WE1 is high.
- Addr0  out  ADDR_W  Buf0 write address.
- Addr1  out  ADDR_W  Buf1 write address.
- row0  out  7  row index currently being written in Buf0.
- row1  out  7  row index currently being written in Buf1.
- Buf0Full  out  1  Buf0 holds a complete, unread frame.
- Buf1Full  out  1  Buf1 holds a complete, unread frame.
- FrameDone  out  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (reset low, async). All outputs are 0, including DataReady, WE0/WE1, WrData, Addr0/1, row0/1, Buf0Full/Buf1Full and FrameDone. The following internal state also resets:
  - state = SEL, target = Buf0;
  - byte phase = 0, column = 0.
- Reset mid-frame discards the partial frame; both Full flags clear.
- States:
  - SEL: if the target buffer's Full flag is 0, clear that buffer's Addr/row/column, then go to FILL0 or FILL1 on the next edge. Otherwise wait in SEL.
  - FILL0 / FILL1: DataReady = CSHost. A byte is accepted on an edge where DataValid && DataReady && CSHost.
  - DONE: one cycle. Toggle target, then return to SEL.
- Byte phase (0 = R, 1 = G, 2 = B): advances on each accepted byte and wraps 2 -> 0. R and G are latched. On acceptance of B:
  - WrData <= {R,G,DataIn} and WEx <= 1 for exactly the next cycle (latency 1 edge after the B byte);
  - Addr of the target buffer is the current pixel address; it increments by 1 on the edge after the WE cycle;
  - column advances; at COLS-1 it wraps to 0 and rowx increments.
- Last pixel (rowx == ROWS-1, column == COLS-1, B accepted):
  - go to DONE, so DataReady drops on the following cycle;
  - WEx, FrameDone and BufxFull all set for that same next cycle;
  - rowx holds ROWS-1 and Addr holds the last address (no increment past ROWS*COLS-1).
- Full flags:
  - BufxFull sets at frame completion and clears on an edge where BufxEmpty is high.
  - If completion and BufxEmpty coincide on the same edge, set wins.
  - BufxEmpty has no effect on a buffer being filled.
- WE0 and WE1 are never high together. No WE is issued outside a FILL state, except the final-pixel WE, which lands in the DONE cycle.
- CSHost low: DataReady = 0 and phase/column/row/state hold. A pending WE cycle still completes. DataValid without DataReady is ignored; no byte is consumed.
- Host pausing mid-pixel (DataValid low between R/G/B) is legal; the phase is retained indefinitely.
- Arithmetic: all counters are unsigned. The address is a linear count equal to row*COLS+column. No overflow is possible given the parameter constraints.

Test Plan:
- Reset, then stream 3 bytes 0x11, 0x22, 0x33 (ROWS=2, COLS=2) -> one cycle after the 0x33 edge: WE0=1, WrData=0x112233, Addr0=0; then Addr0=1; WE1 stays 0.
- Full frame of 4 pixels into Buf0 (ROWS=2, COLS=2) -> row0 goes 0,0,1,1. On the last WE0 cycle FrameDone=1 and Buf0Full=1; DataReady low for the DONE cycle, then high again with WE1 used for the next frame at Addr1=0, row1=0.
- Fill Buf0 and Buf1 with Buf0Empty=0 -> writer parks in SEL with DataReady=0. Pulse Buf0Empty=1 for one cycle -> Buf0Full clears, then DataReady=1 two cycles later and Addr0/row0 restart at 0.
- DataValid held high while toggling CSHost low for 5 cycles mid-pixel (after R, before G) -> no bytes consumed and phase retained. The resulting WrData packs the R before the gap with the G and B after it.
- Assert reset low mid-frame at pixel 2 -> all outputs 0 immediately (asynchronous); after release the next pixel is written to Buf0 at Addr0=0.
- Buf1Empty high on the same edge Buf1 completes -> Buf1Full=1 afterward.
